manhattan_ring_gen: RTL
=======================

MANHATTAN_RING_GEN -- requirements
Module: manhattan_ring_gen

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  high only in IDLE.
REQ-006 cx, cy  input  15 each  centre point, unsigned.
REQ-007 radius  input  16  Manhattan distance d, unsigned.
REQ-008 pt_valid  output  1  point available.
REQ-009 pt_ready  input  1  consumer accepts point.
REQ-010 px, py  output  15 each  emitted point (low 15 bits of signed 17-bit result).
REQ-011 pt_last  output  1  point has enumeration index 4d-1, or is the single d=0 point.
REQ-012 pt_oob  output  1  point lies outside [0,32767] on either axis (tied 0 when MANHATTAN_CLIP_EN is defined).
REQ-013 done  output  1  one-cycle pulse when the enumeration is complete.

Function
REQ-014 SHALL enumerate every lattice point at exact Manhattan distance d from (cx,cy): the inverse direction of the team's distance blocks.
REQ-015 States SHALL be IDLE and GEN; IDLE->GEN on cmd_valid&&cmd_ready, latching cx, cy and radius.
REQ-016 d=0 SHALL produce exactly one point, (cx,cy).
REQ-017 For d>0 the block SHALL produce 4d points as quadrant q=0..3, t=0..d-1: q0 (cx+d-t, cy+t); q1 (cx-t, cy+d-t); q2 (cx-d+t, cy-t); q3 (cx+t, cy-d+t).
REQ-018 Coordinate arithmetic SHALL be 17-bit signed; in range iff 0 <= v <= 32767.
REQ-019 Counters SHALL be t (16 bits) and q (2 bits); t wraps to 0 and q increments when t reaches d-1.
REQ-020 pt_valid SHALL first assert in the cycle after command acceptance.
REQ-021 Outputs SHALL be registered; px, py, pt_last and pt_oob SHALL stay stable while pt_valid && !pt_ready.
REQ-022 Throughput SHALL be one point per cycle while pt_ready is held high.
REQ-023 After the final point is accepted (or skipped), done SHALL pulse for one cycle and the state SHALL return to IDLE in that same cycle, with cmd_ready high.
REQ-024 cmd_valid in GEN SHALL be ignored; latched operands SHALL NOT change.
REQ-025 pt_ready asserted while pt_valid is low SHALL have no effect.

Reset
REQ-026 Reset SHALL force IDLE, with cmd_ready=1 and pt_valid=0, pt_last=0, pt_oob=0, done=0, px=0, py=0, t=0, q=0.
REQ-027 Reset asserted mid-enumeration SHALL abort it with no done pulse; the in-flight point is discarded.

Configuration
REQ-028 Macro MANHATTAN_CLIP_EN defined: out-of-range points SHALL be suppressed (pt_valid low, one cycle consumed each).
- pt_last SHALL assert only if index 4d-1 is in range.
- done SHALL still pulse, including when every point is suppressed.
REQ-029 MANHATTAN_CLIP_EN undefined: every point SHALL be emitted, with pt_oob flagging out-of-range points.

Verification
REQ-030 cx=5, cy=7, d=0 -> single point (5,7) with pt_last=1; done pulses the cycle after acceptance.
REQ-031 cx=10, cy=10, d=1, pt_ready=1 -> points on consecutive cycles (11,10), (10,11), (9,10), (10,9); pt_last on the 4th only.
REQ-032 cx=100, cy=100, d=3, pt_ready low 3 cycles at the 5th point -> that point is held stable; all 12 points arrive in order with none lost or duplicated.
REQ-033 cx=0, cy=0, d=1:
- With MANHATTAN_CLIP_EN: (1,0), (0,1), no pt_last, then done.
- Without it: 4 points, pt_oob=1 on the 3rd (-1,0) and the 4th (0,-1); pt_last with pt_oob=1 on the 4th.
REQ-034 cx=0, cy=0, d=65535 with MANHATTAN_CLIP_EN -> no pt_valid for 4*65535 cycles, then a single done pulse.
REQ-035 rst_n low at the 3rd point of d=2 -> pt_valid=0 immediately, no done; after release, cmd_ready=1 and a new command enumerates correctly.

Source files
------------

// File: rtl/manhattan_ring_gen.sv
// Manhattan ring generator: enumerates every lattice point at exact Manhattan
// distance d from a centre point, one point per cycle under ready/valid flow
// control. Quadrant q = 0..3 and step t = 0..d-1 select the point.
// Optional build macro: MANHATTAN_CLIP_EN suppresses out-of-range points
// instead of flagging them on pt_oob.
module manhattan_ring_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [14:0] cx,
    input  logic [14:0] cy,
    input  logic [15:0] radius,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic [14:0] px,
    output logic [14:0] py,
    output logic        pt_last,
    output logic        pt_oob,
    output logic        done
);

    typedef enum logic [0:0] {StIdle, StGen} state_e;

    state_e      state_q;
    logic [14:0] cx_q, cy_q;
    logic [15:0] radius_q;
    logic [15:0] t_q;
    logic [1:0]  q_q;
    logic        pt_valid_q, pt_last_q, pt_oob_q, done_q;
    logic [14:0] px_q, py_q;

    logic        is_last, t_wrap, advance;
    logic [15:0] nt;
    logic [1:0]  nq;
    logic [16:0] bx, by, bd, bt;
    logic [1:0]  bq;
    logic [16:0] vx, vy;
    logic        ld_last, ld_inr;

    assign cmd_ready = (state_q == StIdle);
    assign pt_valid  = pt_valid_q;
    assign pt_last   = pt_last_q;
    assign pt_oob    = pt_oob_q;
    assign px        = px_q;
    assign py        = py_q;
    assign done      = done_q;

    // Step control and the coordinates of the point to load next: the first
    // point from the raw command in IDLE, the successor of (q,t) in GEN.
    always_comb begin
        is_last = (radius_q == 16'd0) || ((q_q == 2'd3) && (t_q == radius_q - 16'd1));
        t_wrap  = (t_q == radius_q - 16'd1);
        nt      = t_wrap ? 16'd0 : t_q + 16'd1;
        nq      = t_wrap ? q_q + 2'd1 : q_q;
        // A suppressed point (pt_valid low in GEN) is consumed without a handshake.
        advance = !pt_valid_q || pt_ready;

        if (state_q == StIdle) begin
            bx      = {2'b00, cx};
            by      = {2'b00, cy};
            bd      = {1'b0, radius};
            bq      = 2'd0;
            bt      = 17'd0;
            ld_last = (radius == 16'd0);
        end else begin
            bx      = {2'b00, cx_q};
            by      = {2'b00, cy_q};
            bd      = {1'b0, radius_q};
            bq      = nq;
            bt      = {1'b0, nt};
            ld_last = (nq == 2'd3) && (nt == radius_q - 16'd1);
        end

        // Modulo-2^17 arithmetic is identical to 17-bit signed arithmetic.
        vx = 17'd0;
        vy = 17'd0;
        unique case (bq)
            2'd0: begin vx = bx + bd - bt; vy = by + bt;      end
            2'd1: begin vx = bx - bt;      vy = by + bd - bt; end
            2'd2: begin vx = bx - bd + bt; vy = by - bt;      end
            2'd3: begin vx = bx + bt;      vy = by - bd + bt; end
            default: begin vx = 17'd0;     vy = 17'd0;        end
        endcase
        ld_inr = (vx[16:15] == 2'b00) && (vy[16:15] == 2'b00);
    end

    // Command latch, enumeration stepping and registered point outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cx_q       <= 15'd0;
            cy_q       <= 15'd0;
            radius_q   <= 16'd0;
            t_q        <= 16'd0;
            q_q        <= 2'd0;
            pt_valid_q <= 1'b0;
            pt_last_q  <= 1'b0;
            pt_oob_q   <= 1'b0;
            done_q     <= 1'b0;
            px_q       <= 15'd0;
            py_q       <= 15'd0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == StIdle && cmd_valid) || (state_q == StGen && advance && !is_last)) begin
                if (state_q == StIdle) begin
                    state_q  <= StGen;
                    cx_q     <= cx;
                    cy_q     <= cy;
                    radius_q <= radius;
                    t_q      <= 16'd0;
                    q_q      <= 2'd0;
                end else begin
                    t_q <= nt;
                    q_q <= nq;
                end
                px_q <= vx[14:0];
                py_q <= vy[14:0];
`ifdef MANHATTAN_CLIP_EN
                pt_valid_q <= ld_inr;
                pt_last_q  <= ld_last && ld_inr;
                pt_oob_q   <= 1'b0;
`else
                pt_valid_q <= 1'b1;
                pt_last_q  <= ld_last;
                pt_oob_q   <= !ld_inr;
`endif
            end else if (state_q == StGen && advance) begin
                // Final index consumed: finish and accept a new command next cycle.
                state_q    <= StIdle;
                done_q     <= 1'b1;
                pt_valid_q <= 1'b0;
                pt_last_q  <= 1'b0;
                pt_oob_q   <= 1'b0;
            end
        end
    end

endmodule
